// File: rtl/process_element_mul_arb_pkg.sv
// Shared widths and tracking-entry type for the PE multiplier arbiter.
package pe_mul_pkg;
  localparam int A_W  = 16;
  localparam int B_W  = 9;
  localparam int P_W  = 25;
  localparam int ID_W = 3;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
    logic            last;
  } trk_t;
endpackage

// File: rtl/process_element_mul_arb_rr_arbiter.sv
// Round-robin grant over N requesters; pointer moves past the winner on advance.
module pe_rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic          grant_valid,
  output logic [IW-1:0] grant_id
);
  logic [IW-1:0] rr_ptr;
  int idx;

  // Scan from farthest to nearest so the lane closest to rr_ptr wins last.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_id    = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= (grant_id == IW'(N - 1)) ? '0 : grant_id + 1'b1;
    end
  end
endmodule

// File: rtl/process_element_mul_arb.sv
// Shares one pipelined 16x9 multiplier among PE lanes and accumulates per lane.
// Optional PE_MUL_ARB_SAT_EN: saturate sums instead of wrapping.
module process_element_mul_arb
  import pe_mul_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MUL_LAT = 3,
  parameter int ACC_W   = 32,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic                   mul_ce,
  output logic [A_W-1:0]         mul_din0,
  output logic [B_W-1:0]         mul_din1,
  input  logic [P_W-1:0]         mul_dout,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [IW-1:0]          res_id,
  output logic [ACC_W-1:0]       res_data
);
  logic          stall, accept, grant_valid, retire;
  logic [IW-1:0] grant_id;
  trk_t          pipe [MUL_LAT];
  trk_t          pipe_in, pipe_out;

  logic signed [ACC_W-1:0] acc [NUM_REQ];
  logic signed [ACC_W-1:0] acc_sel, sum;
  logic signed [ACC_W:0]   sum_wide;

  assign stall  = res_valid & ~res_ready;
  assign mul_ce = ~stall;
  assign accept = grant_valid & mul_ce;

  pe_rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk         (clk),
    .reset       (reset),
    .req         (req_valid),
    .advance     (accept),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    req_ready = '0;
    mul_din0  = '0;
    mul_din1  = '0;
    if (accept) begin
      req_ready[grant_id] = 1'b1;
      mul_din0 = req_a[grant_id*A_W +: A_W];
      mul_din1 = req_b[grant_id*B_W +: B_W];
    end
  end

  always_comb begin
    pipe_in.vld  = accept;
    pipe_in.id   = ID_W'(grant_id);
    pipe_in.last = accept & req_last[grant_id];
  end

  // Owner tracking moves in lockstep with the multiplier's enabled pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MUL_LAT; i++) pipe[i] <= '0;
    end else if (mul_ce) begin
      pipe[0] <= pipe_in;
      for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign pipe_out = pipe[MUL_LAT-1];
  assign retire   = pipe_out.vld & mul_ce;

  always_comb begin
    acc_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pipe_out.id == ID_W'(i)) acc_sel = acc[i];
    end
    sum_wide = {acc_sel[ACC_W-1], acc_sel}
             + {{(ACC_W + 1 - P_W){mul_dout[P_W-1]}}, mul_dout};
`ifdef PE_MUL_ARB_SAT_EN
    if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
      sum = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      sum = sum_wide[ACC_W-1:0];
    end
`else
    sum = sum_wide[ACC_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) acc[i] <= '0;
    end else if (retire) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (pipe_out.id == ID_W'(i)) acc[i] <= pipe_out.last ? '0 : sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_id    <= '0;
      res_data  <= '0;
    end else begin
      if (res_valid & res_ready) res_valid <= 1'b0;
      if (retire & pipe_out.last) begin
        res_valid <= 1'b1;
        res_id    <= IW'(pipe_out.id);
        res_data  <= sum;
      end
    end
  end
endmodule
